// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a small instruction
// buffer, with redirect handling that drops responses to stale in-flight requests.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);

  logic [63:0]   fetch_pc_r;
  logic [63:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_cnt_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [63:0]   pc_mem_r    [DEPTH];

  logic [CW:0]   occupancy_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          push_s;
  logic          out_valid_s;
  logic          pop_s;
  logic          not_empty_s;
  logic [63:0]   redirect_aligned_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == LAST_W) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  // Handshake qualification; a request is only offered when a buffer slot is reserved for it.
  always_comb begin
    occupancy_s        = {1'b0, outstanding_r} + {1'b0, count_r};
    not_empty_s        = (count_r != {CW{1'b0}});
    req_valid_s        = !rst && !redirect_valid && (occupancy_s < DEPTH_W);
    req_fire_s         = req_valid_s && imem_req_ready;
    rsp_fire_s         = !rst && imem_rsp_valid && (outstanding_r != {CW{1'b0}});
    push_s             = rsp_fire_s && (discard_cnt_r == {CW{1'b0}}) && !redirect_valid;
    out_valid_s        = !rst && not_empty_s && !redirect_valid;
    pop_s              = out_valid_s && out_ready;
    redirect_aligned_s = {redirect_pc[63:2], 2'b00};
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = rst ? RESET_PC : fetch_pc_r;
  assign out_valid      = out_valid_s;
  assign out_instr      = (!rst && not_empty_s) ? instr_mem_r[head_r] : 32'h0000_0000;
  assign out_pc         = (!rst && not_empty_s) ? pc_mem_r[head_r]    : 64'h0;

  // Control state: PCs, credit counters, discard counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_cnt_r <= {CW{1'b0}};
      count_r       <= {CW{1'b0}};
      head_r        <= {AW{1'b0}};
      tail_r        <= {AW{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(rsp_fire_s);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path and must be dropped.
        fetch_pc_r    <= redirect_aligned_s;
        rsp_pc_r      <= redirect_aligned_s;
        discard_cnt_r <= outstanding_r - CW'(rsp_fire_s);
        count_r       <= {CW{1'b0}};
        head_r        <= {AW{1'b0}};
        tail_r        <= {AW{1'b0}};
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + 64'd4;
        end
        if (rsp_fire_s && (discard_cnt_r != {CW{1'b0}})) begin
          discard_cnt_r <= discard_cnt_r - CW'(1);
        end
        if (push_s) begin
          tail_r   <= ptr_inc(tail_r);
          rsp_pc_r <= rsp_pc_r + 64'd4;
        end
        if (pop_s) begin
          head_r <= ptr_inc(head_r);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

  // Buffer storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= imem_rsp_data;
      pc_mem_r[tail_r]    <= rsp_pc_r;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: memory model with variable latency, an epoch-tagged
// request scoreboard, and per-cycle checks of handshake outputs.
module tb_ifu;

  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; } exp_t;

  req_t mem_q [$];
  exp_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int epoch    = 0;
  int m_out    = 0;
  int buffered = 0;
  logic [63:0] m_fetch = RESET_PC;

  // stimulus knobs
  logic        rst_knob   = 1'b1;
  logic        ready_knob = 1'b1;
  logic        ready_rand = 1'b0;
  logic        oready_knob = 1'b1;
  logic        oready_rand = 1'b0;
  logic        stray_knob = 1'b0;
  logic        redir_pend = 1'b0;
  logic [63:0] redir_tgt  = 64'h0;
  logic        arm_redir  = 1'b0;
  logic [63:0] arm_tgt    = 64'h0;
  int          lat        = 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    mem_word = a[31:0] ^ a[63:32] ^ 32'hC0DE_5A00;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    req_t e;
    exp_t x;
    logic rsp_live;
    logic exp_rv;
    logic exp_ov;
    @(posedge clk);
    #1;
    cyc++;
    rst            = rst_knob;
    redirect_valid = redir_pend;
    redirect_pc    = redir_tgt;
    redir_pend     = 1'b0;
    imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_knob;
    out_ready      = oready_rand ? 1'($urandom_range(0, 1)) : oready_knob;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rsp_live       = 1'b0;
    if (rst) begin
      mem_q.delete();
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      e = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(e.addr);
      rsp_live       = 1'b1;
      if (arm_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = arm_tgt;
        arm_redir      = 1'b0;
      end
    end else if (stray_knob) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'($urandom);
    end
    #1;
    if (rst) begin
      check_eq("rst_req_valid", 64'(imem_req_valid), 64'h0);
      check_eq("rst_out_valid", 64'(out_valid), 64'h0);
      check_eq("rst_out_instr", 64'(out_instr), 64'h0);
      check_eq("rst_out_pc", out_pc, 64'h0);
      check_eq("rst_req_addr", imem_req_addr, RESET_PC);
      sb_q.delete();
      m_out    = 0;
      buffered = 0;
      epoch++;
      m_fetch  = RESET_PC;
    end else begin
      exp_rv = !redirect_valid && ((m_out + buffered) < DEPTH);
      exp_ov = (buffered > 0) && !redirect_valid;
      check_eq("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (imem_req_valid) check_eq("req_addr", imem_req_addr, m_fetch);
      check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
      if (buffered == 0) begin
        check_eq("empty_instr", 64'(out_instr), 64'h0);
        check_eq("empty_pc", out_pc, 64'h0);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'(sb_q.size()), 64'h1);
        end else begin
          x = sb_q.pop_front();
          check_eq("out_pc", out_pc, x.pc);
          check_eq("out_instr", 64'(out_instr), 64'(x.instr));
          buffered--;
        end
      end
      if (rsp_live) begin
        m_out--;
        if (e.epoch == epoch && !redirect_valid) buffered++;
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat});
        sb_q.push_back('{instr: mem_word(imem_req_addr), pc: imem_req_addr});
        m_out++;
        m_fetch = m_fetch + 64'd4;
      end
      if (redirect_valid) begin
        sb_q.delete();
        buffered = 0;
        epoch++;
        m_fetch = {redirect_pc[63:2], 2'b00};
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_out + buffered) != 0 && k < 60) begin
      step();
      k++;
    end
    check_eq("drain", 64'(m_out + buffered), 64'h0);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;

    // reset, including a redirect attempt during reset
    run(2);
    redir_pend = 1'b1; redir_tgt = 64'h4000;
    run(1);
    rst_knob = 1'b0;

    // streaming with 1-cycle memory
    lat = 1; run(20);

    // backpressure from decode: buffer fills, requests stall
    oready_knob = 1'b0; run(10);
    check_eq("full_buffered", 64'(buffered), 64'(DEPTH));
    oready_knob = 1'b1; run(10);

    // longer latency, random decode readiness
    lat = 3; oready_rand = 1'b1; run(30);
    oready_rand = 1'b0; oready_knob = 1'b1;

    // redirect with requests in flight
    lat = 4; run(3);
    redir_pend = 1'b1; redir_tgt = 64'h1003; run(20);

    // redirect coinciding with a response while two are outstanding
    lat = 3; run(4);
    arm_redir = 1'b1; arm_tgt = 64'h2000; run(20);

    // memory not ready for 5 cycles
    ready_knob = 1'b0; run(5);
    ready_knob = 1'b1; run(5);

    // stray responses with nothing outstanding
    ready_knob = 1'b0; drain();
    stray_knob = 1'b1; run(4);
    stray_knob = 1'b0; ready_knob = 1'b1;

    // address wrap
    lat = 1; redir_pend = 1'b1; redir_tgt = 64'hFFFF_FFFF_FFFF_FFFC; run(12);

    // random mix
    ready_rand = 1'b1; oready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) begin
        redir_pend = 1'b1;
        redir_tgt  = {32'($urandom), 32'($urandom)};
      end
      if ($urandom_range(0, 31) == 0) begin
        arm_redir = 1'b1;
        arm_tgt   = {32'($urandom), 32'($urandom)};
      end
      step();
    end
    arm_redir = 1'b0;

    // reset mid-stream, then restart
    ready_rand = 1'b0; oready_rand = 1'b0; ready_knob = 1'b1; oready_knob = 1'b1;
    run(5);
    rst_knob = 1'b1; run(2);
    rst_knob = 1'b0; run(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Parameters
REQ-001 SHALL provide RESET_PC, default 64'h0000_0000_0000_0000, the first fetch address after reset (bits [1:0] always zero).
REQ-002 SHALL provide DEPTH, default 2, the instruction-buffer entries and the maximum in-flight fetches combined.

Interface
REQ-003 SHALL have: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have: rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have: imem_req_valid  out  1  fetch request valid.
REQ-006 SHALL have: imem_req_ready  in  1  memory accepts request.
REQ-007 SHALL have: imem_req_addr  out  64  fetch byte address, 4-byte aligned.
REQ-008 SHALL have: imem_rsp_valid  in  1  fetch data valid; in request order, latency >= 1 cycle, no backpressure.
REQ-009 SHALL have: imem_rsp_data  in  32  fetched instruction word.
REQ-010 SHALL have: redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
REQ-011 SHALL have: redirect_pc  in  64  redirect target; bits [1:0] ignored and treated as zero.
REQ-012 SHALL have: out_valid  out  1  instruction available to decode/igu.
REQ-013 SHALL have: out_ready  in  1  decode consumes instruction.
REQ-014 SHALL have: out_instr  out  32  instruction word to decode/igu.
REQ-015 SHALL have: out_pc  out  64  address of out_instr.

Function
REQ-016 SHALL hold fetch_pc, next address to request; imem_req_addr = fetch_pc.
REQ-017 SHALL assert imem_req_valid iff !rst, !redirect_valid and (outstanding + count) < DEPTH, where count = buffered entries.
REQ-018 SHALL, on imem_req_valid && imem_req_ready, advance fetch_pc by 4 (mod 2^64) and increment outstanding.
REQ-019 SHALL keep imem_req_addr stable while imem_req_valid is high and imem_req_ready low.
REQ-020 SHALL, when imem_rsp_valid with discard_cnt = 0, decrement outstanding and push {imem_rsp_data, rsp_pc} into the FIFO; rsp_pc then advances by 4.
REQ-021 SHALL, when imem_rsp_valid with discard_cnt > 0, decrement outstanding and discard_cnt and push nothing.
REQ-022 SHALL ignore imem_rsp_valid when outstanding = 0 (no state change).
REQ-023 SHALL drive out_valid = (count > 0) && !redirect_valid; out_instr/out_pc = FIFO head, and 0/0 when empty.
REQ-024 SHALL pop the head on out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-025 SHALL never overflow: the credit rule (REQ-017) guarantees a slot for every accepted request.
REQ-026 Latency: a response arriving in cycle N SHALL appear on out_valid in cycle N+1.
REQ-027 SHALL, on redirect_valid in cycle T (rising edge ending T):
- clear FIFO (count = 0);
- fetch_pc and rsp_pc <= {redirect_pc[63:2], 2'b00};
- discard_cnt <= outstanding - (imem_rsp_valid && outstanding > 0 ? 1 : 0); outstanding updated per REQ-021/022.
REQ-028 SHALL ignore out_ready in cycle T (no pop); first new request SHALL be issued in T+1 at the earliest.
REQ-029 SHALL let a second redirect arriving while discard_cnt > 0 recompute discard_cnt from the current outstanding, per REQ-027.
REQ-030 SHALL wrap fetch_pc and rsp_pc from 64'hFFFF_FFFF_FFFF_FFFC to 0 with no special handling.

Reset
REQ-031 SHALL, while rst high: fetch_pc = rsp_pc = RESET_PC, count = outstanding = discard_cnt = 0; imem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0, imem_req_addr = RESET_PC.
REQ-032 SHALL apply rst over every other input including a simultaneous redirect; responses to pre-reset requests are the environment's responsibility to suppress.
REQ-033 SHALL issue the first request in the first cycle after rst deasserts.

Verification
REQ-034 Reset release, ready=1, 1-cycle memory, out_ready=1 -> requests 0x0,0x4,0x8...; out_pc 0x0 in cycle 2, one instruction per cycle.
REQ-035 out_ready=0 with DEPTH=2 -> exactly two requests accepted, count=2, imem_req_valid low until a pop; out_instr/out_pc held.
REQ-036 Two requests in flight, redirect to 0x1003 -> both responses dropped, next request addr 0x1000, first out_pc 0x1000.
REQ-037 Redirect in the same cycle as a response with outstanding=2 -> that response dropped, discard_cnt=1, only post-redirect data delivered.
REQ-038 imem_req_ready low 5 cycles -> imem_req_addr stable, no fetch_pc advance; stray imem_rsp_valid with outstanding=0 -> no output.
REQ-039 Redirect to 0xFFFF_FFFF_FFFF_FFFC -> out_pc sequence ...FFFC then 0x0; rst asserted mid-stream -> all outputs at reset values next cycle.
